// File: rtl/cache_mem_arbiter_pkg.sv
// Shared CPU-side definitions for the cache/memory arbiter: FSM encodings and
// the fixed byte-enable pattern used for instruction fetches.
package cache_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arb_state_t;

    // Instruction fetches always read a full word.
    localparam logic [3:0] ICACHE_SEL = 4'hF;

endpackage

// File: rtl/cache_mem_arbiter_rr_pick2.sv
// Two-way round-robin pick between icache (gnt[0]) and dcache (gnt[1]).
// On a tie the requester that was not served last wins.
module rr_pick2 (
    input  logic       req_i,
    input  logic       req_d,
    input  logic       last_d,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (req_i && req_d) begin
            gnt = last_d ? 2'b01 : 2'b10;
        end else if (req_d) begin
            gnt = 2'b10;
        end else if (req_i) begin
            gnt = 2'b01;
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates icache and dcache requests onto one memory port; one transaction
// at a time, never pre-empted, with an IDLE cycle between grants.
module cache_mem_arbiter
    import cache_mem_arbiter_pkg::*;
#(
    parameter int A_WIDTH = 32,
    parameter bit PRIO_D  = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [A_WIDTH-1:0] i_a,
    input  logic               i_strobe,
    output logic [31:0]        i_dout,
    output logic               i_ready,
    input  logic [A_WIDTH-1:0] d_a,
    input  logic               d_strobe,
    input  logic               d_wr,
    input  logic [31:0]        d_din,
    input  logic [3:0]         d_sel,
    output logic [31:0]        d_dout,
    output logic               d_ready,
    output logic [A_WIDTH-1:0] m_a,
    output logic               m_strobe,
    output logic               m_wr,
    output logic [31:0]        m_din,
    output logic [3:0]         m_sel,
    input  logic [31:0]        m_dout,
    input  logic               m_ready,
    output logic               busy
);

    arb_state_t state;
    logic       last_d;
    logic       flushed;
    logic [1:0] gnt;

    rr_pick2 u_pick (
        .req_i  (i_strobe),
        .req_d  (d_strobe),
        .last_d (last_d),
        .gnt    (gnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            last_d   <= ~PRIO_D;
            flushed  <= 1'b0;
            m_a      <= '0;
            m_strobe <= 1'b0;
            m_wr     <= 1'b0;
            m_din    <= '0;
            m_sel    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    flushed <= 1'b0;
                    if (gnt[1]) begin
                        state    <= GNT_D;
                        m_strobe <= 1'b1;
                        m_a      <= d_a;
                        m_wr     <= d_wr;
                        m_din    <= d_din;
                        m_sel    <= d_sel;
                    end else if (gnt[0]) begin
                        state    <= GNT_I;
                        m_strobe <= 1'b1;
                        m_a      <= i_a;
                        m_wr     <= 1'b0;
                        m_din    <= '0;
                        m_sel    <= ICACHE_SEL;
                    end
                end
                GNT_I: begin
                    if (m_ready) begin
                        state    <= IDLE;
                        m_strobe <= 1'b0;
                        last_d   <= 1'b0;
                    end else if (!i_strobe) begin
                        flushed <= 1'b1;
                    end
                end
                GNT_D: begin
                    if (m_ready) begin
                        state    <= IDLE;
                        m_strobe <= 1'b0;
                        last_d   <= 1'b1;
                    end else if (!d_strobe) begin
                        flushed <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A requester that dropped its strobe at any point in the grant has its
    // response swallowed, even if it re-raises the strobe before m_ready.
    assign i_ready = (state == GNT_I) && m_ready && i_strobe && !flushed;
    assign d_ready = (state == GNT_D) && m_ready && d_strobe && !flushed;
    assign i_dout  = i_ready ? m_dout : '0;
    assign d_dout  = d_ready ? m_dout : '0;
    assign busy    = (state != IDLE);

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: memory responses are driven by hand and
// checked against a queue of expected {is_dcache, data} responses.
module tb_cache_mem_arbiter;

    logic        clk;
    logic        rst;
    logic [31:0] i_a;
    logic        i_strobe;
    logic [31:0] i_dout;
    logic        i_ready;
    logic [31:0] d_a;
    logic        d_strobe;
    logic        d_wr;
    logic [31:0] d_din;
    logic [3:0]  d_sel;
    logic [31:0] d_dout;
    logic        d_ready;
    logic [31:0] m_a;
    logic        m_strobe;
    logic        m_wr;
    logic [31:0] m_din;
    logic [3:0]  m_sel;
    logic [31:0] m_dout;
    logic        m_ready;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;
    logic [32:0] exp_q[$];

    cache_mem_arbiter #(.A_WIDTH(32), .PRIO_D(1'b1)) dut (
        .clk      (clk),
        .rst      (rst),
        .i_a      (i_a),
        .i_strobe (i_strobe),
        .i_dout   (i_dout),
        .i_ready  (i_ready),
        .d_a      (d_a),
        .d_strobe (d_strobe),
        .d_wr     (d_wr),
        .d_din    (d_din),
        .d_sel    (d_sel),
        .d_dout   (d_dout),
        .d_ready  (d_ready),
        .m_a      (m_a),
        .m_strobe (m_strobe),
        .m_wr     (m_wr),
        .m_din    (m_din),
        .m_sel    (m_sel),
        .m_dout   (m_dout),
        .m_ready  (m_ready),
        .busy     (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk1(input string tag, input logic obs, input logic expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk1({tag, "_m_strobe"}, m_strobe, 1'b0);
        chk32({tag, "_m_a"}, m_a, 32'h0);
        chk1({tag, "_m_wr"}, m_wr, 1'b0);
        chk32({tag, "_m_din"}, m_din, 32'h0);
        chk32({tag, "_m_sel"}, {28'h0, m_sel}, 32'h0);
        chk1({tag, "_i_ready"}, i_ready, 1'b0);
        chk1({tag, "_d_ready"}, d_ready, 1'b0);
        chk32({tag, "_i_dout"}, i_dout, 32'h0);
        chk32({tag, "_d_dout"}, d_dout, 32'h0);
        chk1({tag, "_busy"}, busy, 1'b0);
    endtask

    task automatic wait_grant(input string tag);
        int n = 0;
        while (!m_strobe && n < 10) begin
            step();
            n++;
        end
        chk1({tag, "_grant"}, m_strobe, 1'b1);
    endtask

    // Drive one memory response cycle and compare against the scoreboard;
    // an empty queue means the response must be swallowed.
    task automatic complete(input string tag, input logic [31:0] data);
        logic [32:0] e;
        m_ready = 1'b1;
        m_dout  = data;
        #1;
        if (exp_q.size() == 0) begin
            chk1({tag, "_swallow_i_ready"}, i_ready, 1'b0);
            chk1({tag, "_swallow_d_ready"}, d_ready, 1'b0);
            chk32({tag, "_swallow_i_dout"}, i_dout, 32'h0);
            chk32({tag, "_swallow_d_dout"}, d_dout, 32'h0);
        end else begin
            e = exp_q.pop_front();
            chk1({tag, "_i_ready"}, i_ready, !e[32]);
            chk1({tag, "_d_ready"}, d_ready, e[32]);
            chk32({tag, "_rsp_data"}, e[32] ? d_dout : i_dout, e[31:0]);
            chk32({tag, "_other_dout"}, e[32] ? i_dout : d_dout, 32'h0);
        end
        step();
        m_ready = 1'b0;
        m_dout  = 32'h0;
    endtask

    initial begin
        rst = 1'b1;
        i_a = 32'h0; i_strobe = 1'b0;
        d_a = 32'h0; d_strobe = 1'b0; d_wr = 1'b0; d_din = 32'h0; d_sel = 4'h0;
        m_dout = 32'h0; m_ready = 1'b0;
        #3;
        chk_all_zero("reset");
        step();
        step();
        rst = 1'b0;

        // icache-only read, memory latency 3
        i_a = 32'h1FC0_0000;
        i_strobe = 1'b1;
        exp_q.push_back({1'b0, 32'h2408_0001});
        step();
        chk1("ird_m_strobe_c1", m_strobe, 1'b1);
        chk32("ird_m_a", m_a, 32'h1FC0_0000);
        chk1("ird_m_wr", m_wr, 1'b0);
        chk32("ird_m_sel", {28'h0, m_sel}, 32'hF);
        chk1("ird_busy", busy, 1'b1);
        chk1("ird_i_ready_early", i_ready, 1'b0);
        step();
        step();
        chk1("ird_m_strobe_c3", m_strobe, 1'b1);
        chk1("ird_i_ready_c3", i_ready, 1'b0);
        step();
        complete("ird", 32'h2408_0001);
        i_strobe = 1'b0;
        chk1("ird_idle_busy", busy, 1'b0);
        chk1("ird_idle_m_strobe", m_strobe, 1'b0);

        // dcache write with inputs changed mid-grant
        d_wr = 1'b1; d_a = 32'h8000_0010; d_din = 32'hDEAD_BEEF; d_sel = 4'b0011;
        d_strobe = 1'b1;
        exp_q.push_back({1'b1, 32'h1111_2222});
        step();
        chk1("dwr_m_strobe", m_strobe, 1'b1);
        chk32("dwr_m_a", m_a, 32'h8000_0010);
        chk1("dwr_m_wr", m_wr, 1'b1);
        chk32("dwr_m_din", m_din, 32'hDEAD_BEEF);
        chk32("dwr_m_sel", {28'h0, m_sel}, 32'h3);
        d_wr = 1'b0; d_a = 32'h0; d_din = 32'h0; d_sel = 4'hF;
        step();
        chk32("dwr_hold_m_a", m_a, 32'h8000_0010);
        chk1("dwr_hold_m_wr", m_wr, 1'b1);
        chk32("dwr_hold_m_din", m_din, 32'hDEAD_BEEF);
        chk32("dwr_hold_m_sel", {28'h0, m_sel}, 32'h3);
        chk1("dwr_i_ready", i_ready, 1'b0);
        step();
        complete("dwr", 32'h1111_2222);
        d_strobe = 1'b0;
        chk1("dwr_ready_once", d_ready, 1'b0);
        step();
        chk1("dwr_idle_busy", busy, 1'b0);

        // reset asserted mid-GNT_D, applied between clock edges
        d_a = 32'h8000_0100; d_strobe = 1'b1;
        step();
        step();
        chk1("rstmid_busy_before", busy, 1'b1);
        #2;
        rst = 1'b1;
        d_strobe = 1'b0;
        #1;
        chk_all_zero("rstmid");
        step();
        rst = 1'b0;
        m_ready = 1'b1;
        m_dout = 32'hCAFE_F00D;
        for (int k = 0; k < 4; k++) begin
            step();
            chk1("postrst_i_ready", i_ready, 1'b0);
            chk1("postrst_d_ready", d_ready, 1'b0);
            chk1("postrst_busy", busy, 1'b0);
        end
        m_ready = 1'b0;
        m_dout = 32'h0;

        // simultaneous requests: reset restores dcache priority, then alternate
        i_a = 32'h0000_1000; d_a = 32'h0000_2000; d_wr = 1'b0; d_sel = 4'hF;
        i_strobe = 1'b1; d_strobe = 1'b1;
        for (int k = 0; k < 4; k++) exp_q.push_back({(k % 2 == 0), 32'hA000_0000 + 32'(k)});
        for (int k = 0; k < 4; k++) begin
            wait_grant("rr");
            chk32("rr_m_a_order", m_a, (k % 2 == 0) ? 32'h0000_2000 : 32'h0000_1000);
            step();
            step();
            complete("rr", 32'hA000_0000 + 32'(k));
            if (k == 3) begin
                i_strobe = 1'b0;
                d_strobe = 1'b0;
            end
            chk1("rr_gap_busy", busy, 1'b0);
            chk1("rr_gap_m_strobe", m_strobe, 1'b0);
        end

        // icache flush: strobe dropped one cycle after the grant
        i_a = 32'h1FC0_0040;
        i_strobe = 1'b1;
        step();
        chk1("flush_grant", m_strobe, 1'b1);
        step();
        i_strobe = 1'b0;
        step();
        chk1("flush_m_strobe_held", m_strobe, 1'b1);
        chk32("flush_m_a_held", m_a, 32'h1FC0_0040);
        step();
        complete("flush", 32'h5555_AAAA);
        chk1("flush_idle_busy", busy, 1'b0);

        // m_ready while idle is ignored
        m_ready = 1'b1;
        m_dout = 32'h7777_7777;
        #1;
        chk1("idle_mready_i_ready", i_ready, 1'b0);
        chk1("idle_mready_d_ready", d_ready, 1'b0);
        step();
        chk1("idle_mready_busy", busy, 1'b0);
        m_ready = 1'b0;

        chk32("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_mem_arbiter.md
CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

Interface
REQ-001 SHALL have parameter A_WIDTH, default 32, the address width of every port.
REQ-002 SHALL have parameter PRIO_D, default 1, selecting the requester that wins the first simultaneous request after reset (1 = dcache).
REQ-003 clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 i_a  in  A_WIDTH  icache miss address.
REQ-006 i_strobe  in  1  icache read request.
REQ-007 i_dout  out  32  read data to icache.
REQ-008 i_ready  out  1  icache transaction complete.
REQ-009 d_a  in  A_WIDTH  dcache address.
REQ-010 d_strobe  in  1  dcache request.
REQ-011 d_wr  in  1  dcache write (1) or read (0).
REQ-012 d_din  in  32  dcache write data.
REQ-013 d_sel  in  4  dcache byte enables.
REQ-014 d_dout  out  32  read data to dcache.
REQ-015 d_ready  out  1  dcache transaction complete.
REQ-016 m_a  out  A_WIDTH  memory address.
REQ-017 m_strobe  out  1  memory request.
REQ-018 m_wr  out  1  memory write.
REQ-019 m_din  out  32  memory write data.
REQ-020 m_sel  out  4  memory byte enables.
REQ-021 m_dout  in  32  memory read data.
REQ-022 m_ready  in  1  memory transaction complete.
REQ-023 busy  out  1  a grant is active.

Function
REQ-024 FSM SHALL have three states: IDLE, GNT_I and GNT_D.
REQ-025 In IDLE with exactly one strobe high, the FSM SHALL move to that requester's grant state on the next edge.
REQ-026 In IDLE with both strobes high, the FSM SHALL grant the requester not granted last (register last_d); after reset, PRIO_D decides.
REQ-027 On entering a grant, m_a, m_wr, m_din and m_sel SHALL be latched from the winner; icache grants drive m_wr=0 and m_sel=4'hF.
REQ-028 m_strobe SHALL be high throughout GNT_I/GNT_D and low in IDLE, so m_strobe rises one cycle after the request.
REQ-029 Latched m_* values SHALL stay stable until m_ready.
REQ-030 On m_ready in a grant, the FSM SHALL pass m_dout combinationally to the granted *_dout, pulse the granted *_ready for that cycle, update last_d, and return to IDLE on the next edge.
REQ-031 The non-granted *_ready SHALL stay 0; the non-granted *_dout SHALL be 0.
REQ-032 If the granted requester drops its strobe mid-grant (flush), the arbiter SHALL hold m_strobe until m_ready, and that requester's *_ready SHALL NOT pulse (response swallowed).
REQ-033 A grant SHALL never be aborted or pre-empted.
REQ-034 Each grant SHALL be followed by at least one IDLE cycle, giving back-to-back throughput of one transaction per (memory latency + 2) cycles.
REQ-035 m_ready in IDLE SHALL be ignored.
REQ-036 busy SHALL equal (state != IDLE).

Reset
REQ-037 rst SHALL force IDLE, last_d = ~PRIO_D, all m_* outputs 0, i_ready = d_ready = 0, *_dout = 0 and busy = 0, immediately and independent of clk.
REQ-038 Reset asserted during a grant SHALL abandon the grant; no *_ready pulse SHALL follow reset release until a new grant completes.

Structure
REQ-039 FSM state encodings and the icache byte-enable constant SHALL live in the shared CPU package.
REQ-040 The round-robin pick SHALL be a sub-module rr_pick2 (inputs: two requests and last_d; outputs: one-hot grant).
REQ-041 The rest of the block SHALL be a single FSM plus output registers.

Verification
REQ-042 icache-only read: i_strobe=1 with i_a=0x1FC0_0000 and memory latency 3 -> m_strobe rises at cycle 1 with m_a=0x1FC0_0000 and m_wr=0; i_ready pulses at cycle 4 with i_dout=m_dout=0x2408_0001.
REQ-043 dcache write: d_wr=1, d_a=0x8000_0010, d_din=0xDEAD_BEEF, d_sel=4'b0011 -> m_* carry exactly these values until m_ready; d_ready pulses once; i_ready stays 0.
REQ-044 Simultaneous requests held high for 4 transactions -> grant order D,I,D,I with PRIO_D=1.
REQ-045 icache flush: i_strobe dropped one cycle after grant -> m_strobe is held until m_ready; i_ready never pulses; the FSM returns to IDLE.
REQ-046 rst asserted mid-GNT_D then released with no strobes -> all outputs 0 asynchronously; busy=0; no spurious ready pulse.
